// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: walks a fetch PC through 1-cycle-latency instruction
// memory and prefetches words into a small FIFO presented via valid/ready.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | not fetching; FIFO contents held and still poppable
// FETCH | issuing reads whenever the FIFO has credit for the response
// HALT  | last program word issued (no wrap); waits for flush
module instr_fetch_unit #(
  parameter int AW       = 5,
  parameter int DW       = 9,
  parameter int DEPTH    = 4,
  parameter int PROG_LEN = 32,
  parameter int WRAP     = 1
) (
  input  logic                     Clock,
  input  logic                     Resetn,
  input  logic                     Run,
  output logic                     mem_rd,
  output logic [AW-1:0]            mem_addr,
  input  logic [DW-1:0]            mem_q,
  output logic [DW-1:0]            instr,
  output logic [AW-1:0]            instr_pc,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  input  logic                     flush,
  input  logic [AW-1:0]            flush_addr,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [AW-1:0] LAST_PC = AW'(PROG_LEN - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t          state;
  logic [AW-1:0]   pc;
  logic [AW-1:0]   next_pc;
  logic [AW-1:0]   issue_pc;
  logic            inflight;
  logic [LW:0]     credit_used;
  logic            push;
  logic            pop;

  logic [DW-1:0]   fifo_data [DEPTH];
  logic [AW-1:0]   fifo_pc   [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [LW-1:0]   count;

  // An outstanding read holds a FIFO slot in reserve, so the response can never overflow.
  assign credit_used = {1'b0, count} + {{LW{1'b0}}, inflight};
  assign mem_rd      = (state == S_FETCH) && Run && !flush &&
                       (credit_used < (LW+1)'(DEPTH));
  assign mem_addr    = pc;
  assign next_pc     = (pc == LAST_PC) ? '0 : pc + AW'(1);

  assign push        = inflight && !flush;
  assign pop         = instr_valid && instr_ready && !flush;

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? fifo_data[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? fifo_pc[rd_ptr]   : '0;
  assign fifo_level  = count;
  assign halted      = (state == S_HALT);

  // Fetch FSM, PC, and the in-flight tracking for the 1-cycle memory latency.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state    <= S_IDLE;
      pc       <= '0;
      issue_pc <= '0;
      inflight <= 1'b0;
    end else begin
      // mem_rd is already low during a flush, so the response slot is cleared too.
      inflight <= mem_rd;
      if (mem_rd) issue_pc <= pc;
      if (flush) begin
        pc    <= flush_addr;
        state <= Run ? S_FETCH : S_IDLE;
      end else begin
        if (mem_rd) pc <= next_pc;
        case (state)
          S_IDLE:  if (Run) state <= S_FETCH;
          S_FETCH: begin
            if (!Run)
              state <= S_IDLE;
            else if (mem_rd && (pc == LAST_PC) && (WRAP == 0))
              state <= S_HALT;
          end
          S_HALT:  ;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // FIFO pointers and occupancy; flush and reset discard everything at once.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: ;
      endcase
    end
  end

  // FIFO storage; unreset because the outputs are masked while empty.
  always_ff @(posedge Clock) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_q;
      fifo_pc[wr_ptr]   <= issue_pc;
    end
  end

  // A push into a full FIFO means the credit accounting above is broken.
  a_no_overflow: assert property (@(posedge Clock) disable iff (!Resetn)
    !(push && !pop && (count == LW'(DEPTH))));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: wrapping instance for fill/stream/flush/wrap/run-drop,
// non-wrapping instance for end-of-program halt.
module tb_instr_fetch_unit;

  localparam int AW = 5;
  localparam int DW = 9;

  logic          Clock;
  logic          Resetn;
  logic          Run;
  logic          instr_ready;
  logic          flush;
  logic [AW-1:0] flush_addr;

  logic          mem_rd, mem_rd_h;
  logic [AW-1:0] mem_addr, mem_addr_h;
  logic [DW-1:0] mem_q, mem_q_h;
  logic [DW-1:0] instr, instr_h;
  logic [AW-1:0] instr_pc, instr_pc_h;
  logic          instr_valid, instr_valid_h;
  logic [2:0]    fifo_level, fifo_level_h;
  logic          halted, halted_h;

  int            vectors;
  int            miscompares;
  int            pop_cnt;
  int            rd_seen;
  int            waited;
  bit            sb_on;
  logic [AW-1:0] last_rd_h;
  logic [AW-1:0] exp_q [$];

  instr_fetch_unit #(.AW(AW), .DW(DW), .DEPTH(4), .PROG_LEN(32), .WRAP(1)) dut (
    .Clock(Clock), .Resetn(Resetn), .Run(Run),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_q(mem_q),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .flush(flush), .flush_addr(flush_addr),
    .fifo_level(fifo_level), .halted(halted)
  );

  instr_fetch_unit #(.AW(AW), .DW(DW), .DEPTH(4), .PROG_LEN(32), .WRAP(0)) dut_h (
    .Clock(Clock), .Resetn(Resetn), .Run(Run),
    .mem_rd(mem_rd_h), .mem_addr(mem_addr_h), .mem_q(mem_q_h),
    .instr(instr_h), .instr_pc(instr_pc_h), .instr_valid(instr_valid_h),
    .instr_ready(instr_ready), .flush(flush), .flush_addr(flush_addr),
    .fifo_level(fifo_level_h), .halted(halted_h)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Instruction memory contents: mem[a] = 9'h100 | a, one cycle read latency.
  always @(posedge Clock) begin
    if (mem_rd)   mem_q   <= {4'b1000, mem_addr};
    if (mem_rd_h) mem_q_h <= {4'b1000, mem_addr_h};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every handshake pop must match the next expected address and word.
  always @(negedge Clock) begin
    if (sb_on && Resetn && !flush && instr_valid && instr_ready) begin
      pop_cnt++;
      chk("sb_expected_available", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        logic [AW-1:0] a;
        a = exp_q.pop_front();
        chk("sb_instr_pc", 32'(instr_pc), 32'(a));
        chk("sb_instr", 32'(instr), 32'({4'b1000, a}));
      end
    end
  end

  task automatic do_reset();
    @(posedge Clock); #1;
    Resetn = 1'b0; Run = 1'b0; instr_ready = 1'b0; flush = 1'b0; flush_addr = '0;
    sb_on = 1'b0;
    exp_q.delete();
    pop_cnt = 0;
    @(posedge Clock); @(posedge Clock); #1;
    Resetn = 1'b1;
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_mem_rd"},   32'(mem_rd), 0);
    chk({pfx, "_mem_addr"}, 32'(mem_addr), 0);
    chk({pfx, "_instr"},    32'(instr), 0);
    chk({pfx, "_instr_pc"}, 32'(instr_pc), 0);
    chk({pfx, "_valid"},    32'(instr_valid), 0);
    chk({pfx, "_level"},    32'(fifo_level), 0);
    chk({pfx, "_halted"},   32'(halted), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vectors = 0; miscompares = 0; pop_cnt = 0; sb_on = 1'b0;
    Resetn = 1'b0; Run = 1'b0; instr_ready = 1'b0; flush = 1'b0; flush_addr = '0;
    last_rd_h = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    chk_reset_vals("rst");
    chk("rst_halted_h", 32'(halted_h), 0);
    chk("rst_valid_h", 32'(instr_valid_h), 0);

    // Fill with backpressure: exactly four reads, then credit runs out.
    @(posedge Clock); #1;
    Resetn = 1'b1; Run = 1'b1;
    rd_seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge Clock);
      if (mem_rd) begin
        chk("fill_addr", 32'(mem_addr), 32'(rd_seen));
        rd_seen++;
      end
    end
    chk("fill_reads", 32'(rd_seen), 4);
    chk("fill_rd_off", 32'(mem_rd), 0);
    chk("fill_level", 32'(fifo_level), 4);
    chk("fill_valid", 32'(instr_valid), 1);
    chk("fill_instr", 32'(instr), 32'h100);
    chk("fill_instr_pc", 32'(instr_pc), 0);

    // Streaming with ready held high.
    do_reset();
    Run = 1'b1; instr_ready = 1'b1; sb_on = 1'b1;
    for (int a = 0; a < 20; a++) exp_q.push_back(AW'(a));
    @(posedge Clock);
    @(negedge Clock);
    chk("lat_e0_valid", 32'(instr_valid), 0);
    chk("lat_e0_rd", 32'(mem_rd), 1);
    @(negedge Clock);
    chk("lat_e1_valid", 32'(instr_valid), 0);
    @(negedge Clock);
    chk("lat_e2_valid", 32'(instr_valid), 1);
    chk("lat_e2_instr", 32'(instr), 32'h100);
    for (int k = 0; k < 12; k++) begin
      @(negedge Clock);
      chk("stream_valid", 32'(instr_valid), 1);
      chk("stream_level_le2", 32'(fifo_level <= 3'd2), 1);
    end
    chk("stream_pops", 32'(pop_cnt >= 12), 1);

    // Flush while the read of address 0 is in flight.
    do_reset();
    Run = 1'b1; instr_ready = 1'b1; sb_on = 1'b1;
    @(posedge Clock);
    @(posedge Clock); #1;
    flush = 1'b1; flush_addr = AW'(10);
    for (int a = 10; a < 30; a++) exp_q.push_back(AW'(a));
    @(negedge Clock);
    chk("fl_rd_blocked", 32'(mem_rd), 0);
    @(posedge Clock); #1;
    flush = 1'b0;
    @(negedge Clock);
    chk("fl_valid_cleared", 32'(instr_valid), 0);
    chk("fl_reissue_rd", 32'(mem_rd), 1);
    chk("fl_reissue_addr", 32'(mem_addr), 10);
    repeat (12) @(negedge Clock);
    chk("fl_pops", 32'(pop_cnt >= 6), 1);

    // Wrap past the end of the program.
    do_reset();
    Run = 1'b1; instr_ready = 1'b1; flush = 1'b1; flush_addr = AW'(28); sb_on = 1'b1;
    for (int a = 28; a < 28 + 20; a++) exp_q.push_back(AW'(a));
    @(posedge Clock); #1;
    flush = 1'b0;
    for (int k = 0; k < 14; k++) begin
      @(negedge Clock);
      chk("wrap_halted", 32'(halted), 0);
    end
    chk("wrap_pops", 32'(pop_cnt >= 8), 1);

    // Halt without wrap on the second instance.
    do_reset();
    Run = 1'b1; instr_ready = 1'b1; flush = 1'b1; flush_addr = AW'(26);
    @(posedge Clock); #1;
    flush = 1'b0;
    waited = 0;
    while (!halted_h && waited < 40) begin
      @(negedge Clock);
      if (mem_rd_h) last_rd_h = mem_addr_h;
      waited++;
    end
    chk("halt_seen", 32'(halted_h), 1);
    chk("halt_last_addr", 32'(last_rd_h), 31);
    chk("halt_rd_off", 32'(mem_rd_h), 0);
    repeat (6) @(negedge Clock);
    chk("halt_rd_still_off", 32'(mem_rd_h), 0);
    chk("halt_held", 32'(halted_h), 1);
    chk("halt_drained", 32'(instr_valid_h), 0);
    chk("halt_level", 32'(fifo_level_h), 0);
    @(posedge Clock); #1;
    instr_ready = 1'b0; flush = 1'b1; flush_addr = '0;
    @(posedge Clock); #1;
    flush = 1'b0;
    @(negedge Clock);
    chk("unhalt_halted", 32'(halted_h), 0);
    chk("unhalt_rd", 32'(mem_rd_h), 1);
    chk("unhalt_addr", 32'(mem_addr_h), 0);
    waited = 0;
    while (!instr_valid_h && waited < 10) begin
      @(negedge Clock);
      waited++;
    end
    chk("unhalt_valid", 32'(instr_valid_h), 1);
    chk("unhalt_instr", 32'(instr_h), 32'h100);
    chk("unhalt_instr_pc", 32'(instr_pc_h), 0);

    // Run drop with a read in flight, then asynchronous reset mid-stream.
    do_reset();
    Run = 1'b1; instr_ready = 1'b0;
    @(posedge Clock);
    @(posedge Clock); #1;
    Run = 1'b0;
    @(negedge Clock);
    chk("rundrop_rd", 32'(mem_rd), 0);
    chk("rundrop_level_pre", 32'(fifo_level), 0);
    @(negedge Clock);
    chk("rundrop_level", 32'(fifo_level), 1);
    chk("rundrop_instr", 32'(instr), 32'h100);
    chk("rundrop_instr_pc", 32'(instr_pc), 0);
    repeat (3) @(negedge Clock);
    chk("rundrop_no_issue", 32'(mem_rd), 0);
    chk("rundrop_level_held", 32'(fifo_level), 1);
    @(posedge Clock); #1;
    Run = 1'b1;
    repeat (3) @(negedge Clock);
    chk("prerst_rd", 32'(mem_rd), 1);
    chk("prerst_valid", 32'(instr_valid), 1);
    #2;
    Resetn = 1'b0;
    #1;
    chk_reset_vals("async_rst");
    @(posedge Clock); #1;
    Resetn = 1'b1; Run = 1'b0;
    @(negedge Clock);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
